// File: rtl/pcie_rx_descrambler.sv
// pcie_rx_descrambler: per-lane PIPE RX descrambler for Gen1/2 (8b/10b) and Gen3 (128b/130b), one cycle of latency
module pcie_rx_descrambler #(
  parameter logic [22:0] LANE_SEED = 23'h1DBFBC
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic [2:0]  gen,
  input  logic [5:0]  pipe_width,
  input  logic        seed_override,
  input  logic [22:0] seed_value,
  input  logic        bypass,
  input  logic [31:0] rx_data,
  input  logic [3:0]  rx_datak,
  input  logic        rx_valid,
  input  logic        rx_start_block,
  input  logic [1:0]  rx_sync_header,
  output logic [31:0] desc_data,
  output logic [3:0]  desc_datak,
  output logic        desc_valid,
  output logic        desc_start_block,
  output logic [1:0]  desc_sync_header,
  output logic        block_align_err
);
  logic [15:0] lfsr16, l16;
  logic [22:0] lfsr23, l23, seed, sv_q;
  logic [3:0]  cnt, c, lane_en;
  logic [1:0]  hdr, h;
  logic [2:0]  gen_q;
  logic [31:0] dout;
  logic [7:0]  d;
  logic [23:0] r16;
  logic [30:0] r23;
  logic        skp_q, eie_q, os_skp, os_eie, aligned, ovr_q;
  logic        g3, act, cfg_chg, data_blk, os_blk, scr_os;
  function automatic logic [23:0] step16(input logic [15:0] s);
    logic [15:0] l;
    logic [7:0]  o;
    l = s;
    o = '0;
    for (int b = 0; b < 8; b++) begin
      o[b] = l[15];
      l = {l[14:0], l[15]} ^ (l[15] ? 16'h0038 : 16'h0000);
    end
    return {o, l};
  endfunction
  function automatic logic [30:0] step23(input logic [22:0] s);
    logic [22:0] l;
    logic [7:0]  o;
    l = s;
    o = '0;
    for (int b = 0; b < 8; b++) begin
      o[b] = l[22];
      l = {l[21:0], l[22]} ^ (l[22] ? 23'h210124 : 23'h000000);
    end
    return {o, l};
  endfunction
  assign seed    = seed_override ? seed_value : LANE_SEED;
  assign g3      = gen >= 3'd3;
  assign lane_en = pipe_width == 6'd8  ? 4'b0001 :
                   pipe_width == 6'd16 ? 4'b0011 :
                   pipe_width == 6'd32 ? 4'b1111 : 4'b0000;
  assign act     = rx_valid && |lane_en;
  assign cfg_chg = gen != gen_q || seed_override != ovr_q || seed_value != sv_q;
  // Symbol chain: each lane sees the LFSR/counter state left by the lane before it
  always_comb begin
    l16 = lfsr16;
    l23 = lfsr23;
    c = cnt;
    h = hdr;
    os_skp = skp_q;
    os_eie = eie_q;
    dout = '0;
    d = '0;
    r16 = '0;
    r23 = '0;
    data_blk = 1'b0;
    os_blk = 1'b0;
    scr_os = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lane_en[i]) begin
        d = rx_data[8*i +: 8];
        r16 = step16(l16);
        r23 = step23(l23);
        if (g3) begin
          if (i == 0 && rx_start_block) begin
            c = '0;
            h = rx_sync_header;
          end
          if (c == 4'd0) begin
            os_skp = d == 8'hAA;
            os_eie = d == 8'h00;
          end
          data_blk = h == 2'b01;
          os_blk = h == 2'b10;
          scr_os = os_blk && !os_skp && !os_eie;
          dout[8*i +: 8] = data_blk || (scr_os && c != 4'd0) ? d ^ r23[30:23] : d;
          l23 = os_blk && os_eie && c == 4'd15 ? seed : data_blk || scr_os ? r23[22:0] : l23;
          c = c + 4'd1;
        end else begin
          dout[8*i +: 8] = rx_datak[i] || bypass ? d : d ^ r16[23:16];
          l16 = rx_datak[i] && d == 8'hBC ? 16'hFFFF : rx_datak[i] && d == 8'h1C ? l16 : r16[15:0];
        end
      end
    end
  end
  // gen_q resets to 0, so the first cycle out of reset reloads LFSR23 from the live seed
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr16 <= 16'hFFFF;
      lfsr23 <= LANE_SEED;
      cnt <= '0;
      hdr <= '0;
      skp_q <= 1'b0;
      eie_q <= 1'b0;
      aligned <= 1'b0;
      gen_q <= '0;
      ovr_q <= 1'b0;
      sv_q <= '0;
      desc_data <= '0;
      desc_datak <= '0;
      desc_valid <= 1'b0;
      desc_start_block <= 1'b0;
      desc_sync_header <= '0;
      block_align_err <= 1'b0;
    end else begin
      gen_q <= gen;
      ovr_q <= seed_override;
      sv_q <= seed_value;
      desc_data <= dout;
      desc_datak <= rx_datak;
      desc_valid <= act;
      desc_start_block <= rx_start_block;
      desc_sync_header <= rx_start_block ? rx_sync_header : hdr;
      block_align_err <= act && g3 && rx_start_block && aligned && cnt != 4'd0;
      if (cfg_chg) begin
        lfsr16 <= 16'hFFFF;
        lfsr23 <= seed;
        cnt <= '0;
      end else if (act) begin
        lfsr16 <= l16;
        lfsr23 <= l23;
        cnt <= c;
      end
      if (act && g3) begin
        hdr <= h;
        skp_q <= os_skp;
        eie_q <= os_eie;
        if (rx_start_block) aligned <= 1'b1;
      end
    end
  end
endmodule
